// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (CPU/DMA) arbiter sequencing single accesses to a
//            single-port memory; optional MEM_ARB_CPU_PRIO_EN = fixed CPU priority.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              c_cnt_w    = $clog2(RD_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_lat_last = c_cnt_w'(RD_LAT - 1);
  localparam logic            c_cpu      = 1'b0;
  localparam logic            c_dma      = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner;
  logic                r_last_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [c_cnt_w-1:0]  r_lat_cnt;
  logic                w_pick_dma;
  logic                w_any_req;

  always_comb begin
    w_next_state = r_state;
    w_any_req    = cpu_req | dma_req;
`ifdef MEM_ARB_CPU_PRIO_EN
    w_pick_dma   = dma_req & ~cpu_req;
`else
    // On contention the requester that was not served last wins
    w_pick_dma   = dma_req & (~cpu_req | (r_last_owner == c_cpu));
`endif
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = r_we ? S_ACK : S_WAIT;
      S_WAIT:  if (r_lat_cnt == c_lat_last) w_next_state = S_ACK;
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= c_cpu;
      r_last_owner <= c_dma;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_lat_cnt    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_pick_dma;
            r_we    <= w_pick_dma ? dma_we    : cpu_we;
            r_addr  <= w_pick_dma ? dma_addr  : cpu_addr;
            r_wdata <= w_pick_dma ? dma_wdata : cpu_wdata;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == c_lat_last) begin
            r_lat_cnt <= '0;
            r_rdata   <= mem_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt + c_cnt_w'(1);
          end
        end
        S_ACK:   r_last_owner <= r_owner;
        default: ;
      endcase
    end
  end

  // Strobes decode from the registered state, so a reset raised during
  // ISSUE still lets that cycle's access reach the memory.
  assign mem_we    = (r_state == S_ISSUE) &  r_we;
  assign mem_re    = (r_state == S_ISSUE) & ~r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;
  assign cpu_ack   = (r_state == S_ACK) & (r_owner == c_cpu);
  assign dma_ack   = (r_state == S_ACK) & (r_owner == c_dma);
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter (RD_LAT=1 and RD_LAT=3 instances).
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
  logic       dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0] dma_addr = 8'h00, dma_wdata = 8'h00;

  logic       cpu_ack1, dma_ack1, cpu_stall1, mem_we1, mem_re1;
  logic [7:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic       cpu_ack2, dma_ack2, cpu_stall2, mem_we2, mem_re2;
  logic [7:0] rdata2, mem_addr2, mem_wdata2, mem_rdata2;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack1), .rdata(rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_re(mem_re1),
    .mem_rdata(mem_rdata1)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut2 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack2), .cpu_stall(cpu_stall2),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack2), .rdata(rdata2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_re(mem_re2),
    .mem_rdata(mem_rdata2)
  );

  // Memory models: read data is valid only in the RD_LAT-th cycle after mem_re
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic [7:0] p1;
  logic [7:0] p2 [3];

  always @(posedge clock) begin
    if (reset) begin
      mem1[8'h20] <= 8'h3C;
      mem1[8'h21] <= 8'h5A;
      mem2[8'h50] <= 8'h9E;
    end
    if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
    if (mem_we2) mem2[mem_addr2] <= mem_wdata2;
    p1    <= mem_re1 ? mem1[mem_addr1] : 8'h00;
    p2[0] <= mem_re2 ? mem2[mem_addr2] : 8'h00;
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end
  assign mem_rdata1 = p1;
  assign mem_rdata2 = p2[2];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rst, creq, cwe;
    logic [7:0] caddr, cwd;
    logic       dreq, dwe;
    logic [7:0] daddr, dwd;
    logic       cack, dack, mwe, mre;
    logic [7:0] maddr, mwd, rd;
    logic       stall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, creq, cwe, input logic [7:0] caddr, cwd,
                     input logic dreq, dwe, input logic [7:0] daddr, dwd,
                     input logic cack, dack, mwe, mre,
                     input logic [7:0] maddr, mwd, rd, input logic stall);
    vec_t v;
    v = '{rst, creq, cwe, caddr, cwd, dreq, dwe, daddr, dwd,
          cack, dack, mwe, mre, maddr, mwd, rd, stall};
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_we = 1'b0; dma_we = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic do_access(input string name, input bit is_dma, input bit we,
                           input logic [7:0] a, d, input int exp_lat, input logic [7:0] exp_rd);
    int cyc;
    bit seen;
    @(posedge clock); #1;
    if (is_dma) begin dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d; end
    else        begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20) begin
      @(negedge clock);
      if (is_dma ? dma_ack1 : cpu_ack1) seen = 1'b1;
      else begin
        cyc++;
        @(posedge clock); #1;
      end
    end
    check({name, " ack_latency"}, cyc, exp_lat);
    if (!we) check({name, " rdata"}, rdata1, exp_rd);
    @(posedge clock); #1;
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n, cyc;
    bit  got [4];
    int  at  [4];
    int  exp_owner;

    //   rst creq cwe caddr cwd   dreq dwe daddr dwd  cack dack mwe mre maddr mwd  rd    stall
    add(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 8'h00,8'h00,8'h00, 0);
    add(0, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,0,0, 8'h00,8'h00,8'h00, 1);
    add(0, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 0,0,1,0, 8'h10,8'hA5,8'h00, 1);
    add(0, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 1,0,0,0, 8'h10,8'hA5,8'h00, 0);
    add(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 8'h10,8'hA5,8'h00, 0);
    add(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,0,0,0, 8'h10,8'hA5,8'h00, 0);
    add(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,0,0,1, 8'h20,8'h00,8'h00, 0);
    add(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,0,0,0, 8'h20,8'h00,8'h00, 0);
    add(0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,1,0,0, 8'h20,8'h00,8'h3C, 0);
    add(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 8'h20,8'h00,8'h3C, 0);
    add(0, 1,1,8'h30,8'h77, 0,0,8'h00,8'h00, 0,0,0,0, 8'h20,8'h00,8'h3C, 1);
    add(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,1,0, 8'h30,8'h77,8'h3C, 0);
    add(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,0,0,0, 8'h30,8'h77,8'h3C, 0);
    add(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 8'h30,8'h77,8'h3C, 0);
    add(0, 0,0,8'h00,8'h00, 1,0,8'h30,8'h00, 0,0,0,0, 8'h30,8'h77,8'h3C, 0);
    add(0, 0,0,8'h00,8'h00, 1,0,8'h30,8'h00, 0,0,0,1, 8'h30,8'h00,8'h3C, 0);
    add(0, 0,0,8'h00,8'h00, 1,0,8'h30,8'h00, 0,0,0,0, 8'h30,8'h00,8'h3C, 0);
    add(0, 0,0,8'h00,8'h00, 1,0,8'h30,8'h00, 0,1,0,0, 8'h30,8'h00,8'h77, 0);
    add(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 8'h30,8'h00,8'h77, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clock); #1;
      reset   = tbl[i].rst;
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
      dma_req = tbl[i].dreq; dma_we = tbl[i].dwe; dma_addr = tbl[i].daddr; dma_wdata = tbl[i].dwd;
      @(negedge clock);
      check($sformatf("row%0d cpu_ack", i),   cpu_ack1,   tbl[i].cack);
      check($sformatf("row%0d dma_ack", i),   dma_ack1,   tbl[i].dack);
      check($sformatf("row%0d mem_we", i),    mem_we1,    tbl[i].mwe);
      check($sformatf("row%0d mem_re", i),    mem_re1,    tbl[i].mre);
      check($sformatf("row%0d mem_addr", i),  mem_addr1,  tbl[i].maddr);
      check($sformatf("row%0d mem_wdata", i), mem_wdata1, tbl[i].mwd);
      check($sformatf("row%0d rdata", i),     rdata1,     tbl[i].rd);
      check($sformatf("row%0d cpu_stall", i), cpu_stall1, tbl[i].stall);
    end

    // Both requesters hold their write requests continuously
    do_reset();
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h11;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h41; dma_wdata = 8'h22;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clock);
      if (cpu_ack1 || dma_ack1) begin
        got[n] = dma_ack1;
        at[n]  = cyc;
        n++;
      end
      cyc++;
      @(posedge clock); #1;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check("contend grant_count", n, 4);
    check("contend first_ack_cycle", at[0], 2);
    for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_CPU_PRIO_EN
      exp_owner = 0;
`else
      exp_owner = i % 2;
`endif
      check($sformatf("contend grant%0d owner_is_dma", i), got[i], exp_owner);
      if (i > 0) check($sformatf("contend gap%0d", i), at[i] - at[i-1], 3);
    end

    // RD_LAT=3 read on the second instance
    do_reset();
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      check($sformatf("lat3 k%0d mem_re", k),  mem_re2,  (k == 1));
      check($sformatf("lat3 k%0d mem_we", k),  mem_we2,  1'b0);
      check($sformatf("lat3 k%0d cpu_ack", k), cpu_ack2, (k == 5));
      check($sformatf("lat3 k%0d rdata", k),   rdata2,   (k == 5) ? 8'h9E : 8'h00);
      @(posedge clock); #1;
    end
    cpu_req = 1'b0;

    // Reset during WAIT kills the pending ack and clears rdata
    do_reset();
    do_access("t5 dma_read", 1'b1, 1'b0, 8'h21, 8'h00, 3, 8'h5A);
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_wait cpu_ack", cpu_ack1, 1'b0);
    check("rst_wait rdata",   rdata1,   8'h00);
    check("rst_wait mem_re",  mem_re1,  1'b0);
    do_access("t5 fresh_write", 1'b0, 1'b1, 8'h60, 8'hC5, 2, 8'h00);
    do_access("t5 readback",    1'b1, 1'b0, 8'h60, 8'h00, 3, 8'hC5);

    // Reset during ISSUE: the write strobe still lands, no ack follows
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h70; cpu_wdata = 8'h99;
    @(posedge clock); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clock);
    check("rst_issue mem_we",   mem_we1,   1'b1);
    check("rst_issue mem_addr", mem_addr1, 8'h70);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_issue cpu_ack",  cpu_ack1,  1'b0);
    check("rst_issue mem_addr_cleared", mem_addr1, 8'h00);
    do_access("rst_issue readback", 1'b1, 1'b0, 8'h70, 8'h00, 3, 8'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
